// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS register window on the
// data-memory bus, serialised onto a registered, glitch-free tx line.
//
// state | meaning
// IDLE  | line high, waiting for an accepted TXDATA write
// START | start bit (low) for CLKS_PER_BIT cycles
// DATA  | data bits 0..7, LSB first, CLKS_PER_BIT cycles each
// STOP  | stop bit (high) for CLKS_PER_BIT cycles
module mmio_uart_tx #(
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = 32'h1001_0040,
  parameter int unsigned           CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  hit,
  output logic                  tx,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned     CNT_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       data_q, data_d;
  logic             ovr_q, ovr_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic wr_tx;
  logic wr_st;
  logic bit_end;
  logic unused_bits;

  assign hit     = (addr[DATA_WIDTH-1:3] == BASE_ADDR[DATA_WIDTH-1:3]);
  assign wr_tx   = we & hit & ~addr[2];
  assign wr_st   = we & hit & addr[2];
  assign bit_end = (cyc_q == CNT_LAST);

  // Byte-lane offset and upper store data have no meaning for this block.
  assign unused_bits = ^{addr[1:0], wdata[DATA_WIDTH-1:8]};

  always_comb begin
    rdata = '0;
    if (hit) begin
      if (addr[2]) begin
        rdata[1:0] = {ovr_q, busy_q};
      end else begin
        rdata[7:0] = data_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    done_d  = 1'b0;

    if (wr_tx && busy_q) begin
      ovr_d = 1'b1;
    end else if (wr_st && wdata[1]) begin
      ovr_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (wr_tx) begin
          state_d = S_START;
          cyc_d   = '0;
          data_d  = wdata[7:0];
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          cyc_d   = '0;
          bit_d   = '0;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cyc_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          state_d = S_IDLE;
          cyc_d   = '0;
          done_d  = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // tx is decoded from next state so the line itself comes straight off a flop.
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = data_d[bit_d];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      data_q  <= 8'h00;
      ovr_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      ovr_q   <= ovr_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed plan steps plus randomized
// frames checked against a frame-level model of the 8N1 line and registers.
module tb_mmio_uart_tx;

  localparam int unsigned N    = 4;
  localparam logic [31:0] BASE = 32'h1001_0040;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        hit;
  logic        tx;
  logic        busy;
  logic        tx_done;

  int vectors = 0;
  int errs    = 0;

  logic [7:0] m_data;
  logic       m_ovr;

  mmio_uart_tx #(
    .DATA_WIDTH  (32),
    .BASE_ADDR   (BASE),
    .CLKS_PER_BIT(N)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .wdata  (wdata),
    .we     (we),
    .rdata  (rdata),
    .hit    (hit),
    .tx     (tx),
    .busy   (busy),
    .tx_done(tx_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "bench timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // 8N1 line value for bit slot idx of a frame carrying b.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic chk_status(input string tag, input logic exp_busy);
    addr = BASE + 32'd4 + 32'($urandom_range(0, 3));
    we   = 1'b0;
    #1;
    chk(tag, rdata, {30'b0, m_ovr, exp_busy});
  endtask

  task automatic chk_txdata(input string tag);
    addr = BASE + 32'($urandom_range(0, 3));
    we   = 1'b0;
    #1;
    chk(tag, rdata, {24'b0, m_data});
  endtask

  task automatic start(input logic [31:0] a, input logic [7:0] b);
    chk("idle_before_start", 32'(busy), 32'd0);
    addr  = a;
    wdata = {24'($urandom), b};
    we    = 1'b1;
    step();
    we     = 1'b0;
    m_data = b;
  endtask

  // Called in the cycle right after the accepting edge; returns in the tx_done cycle.
  task automatic frame(input logic [7:0] b, input int intr_k, input logic [7:0] intr_v);
    for (int k = 0; k < int'(10 * N); k++) begin
      chk("tx_bit", 32'(tx), 32'(frame_bit(b, k / int'(N))));
      chk("busy_in_frame", 32'(busy), 32'd1);
      chk("no_done_in_frame", 32'(tx_done), 32'd0);
      if (k == int'(5 * N + 1)) begin
        chk_status("status_while_busy", 1'b1);
        chk_txdata("txdata_while_busy");
      end
      if (k == intr_k) begin
        addr  = BASE + 32'($urandom_range(0, 3));
        wdata = {24'($urandom), intr_v};
        we    = 1'b1;
        m_ovr = 1'b1;
      end
      step();
      we = 1'b0;
    end
    chk("end_tx_high", 32'(tx), 32'd1);
    chk("end_busy_low", 32'(busy), 32'd0);
    chk("tx_done_pulse", 32'(tx_done), 32'd1);
  endtask

  task automatic idle_cycle();
    step();
    chk("idle_tx", 32'(tx), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(tx_done), 32'd0);
  endtask

  task automatic write_status(input logic [31:0] v);
    addr  = BASE + 32'd4;
    wdata = v;
    we    = 1'b1;
    step();
    we = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int         intr;
    int         sel;

    reset  = 1'b1;
    we     = 1'b0;
    addr   = BASE;
    wdata  = '0;
    m_data = 8'h00;
    m_ovr  = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk_status("rst_status", 1'b0);
    chk_txdata("rst_txdata");
    idle_cycle();

    // 0xA5 frame, then read back TXDATA
    start(BASE, 8'hA5);
    frame(8'hA5, -1, 8'h00);
    chk_txdata("txdata_a5");
    chk("txdata_a5_abs", rdata, 32'h0000_00A5);
    idle_cycle();

    // overrun on a write 10 cycles into a 0x3C frame
    start(BASE, 8'h3C);
    frame(8'h3C, 10, 8'hFF);
    chk_txdata("txdata_kept_3c");
    chk_status("status_ovr_after", 1'b0);
    write_status(32'hFFFF_FFFD);
    chk_status("status_no_clear_bit1_0", 1'b0);
    write_status(32'h0000_0002);
    m_ovr = 1'b0;
    chk_status("status_cleared", 1'b0);
    chk("status_cleared_abs", rdata, 32'h0);

    // mid-frame reset with overrun set
    start(BASE, 8'hC3);
    for (int k = 0; k < 15; k++) begin
      chk("pre_reset_tx", 32'(tx), 32'(frame_bit(8'hC3, k / int'(N))));
      if (k == 2) begin
        addr  = BASE;
        wdata = 32'h77;
        we    = 1'b1;
        m_ovr = 1'b1;
      end
      step();
      we = 1'b0;
    end
    chk_status("ovr_before_reset", 1'b1);
    reset = 1'b1;
    step();
    reset  = 1'b0;
    m_ovr  = 1'b0;
    m_data = 8'h00;
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(tx_done), 32'd0);
    chk_status("mid_rst_status", 1'b0);
    chk_txdata("mid_rst_txdata");
    idle_cycle();
    idle_cycle();

    // address misses
    addr  = BASE + 32'd8;
    wdata = 32'h5A;
    we    = 1'b1;
    #1;
    chk("miss_hi_hit", 32'(hit), 32'd0);
    chk("miss_hi_rdata", rdata, 32'd0);
    step();
    chk("miss_hi_tx", 32'(tx), 32'd1);
    chk("miss_hi_busy", 32'(busy), 32'd0);
    addr = BASE - 32'd4;
    #1;
    chk("miss_lo_hit", 32'(hit), 32'd0);
    chk("miss_lo_rdata", rdata, 32'd0);
    step();
    we = 1'b0;
    chk("miss_lo_tx", 32'(tx), 32'd1);
    chk("miss_lo_busy", 32'(busy), 32'd0);
    chk_status("miss_no_ovr", 1'b0);
    chk("hit_status_window", 32'(hit), 32'd1);

    // back-to-back: 0x55 written in the tx_done cycle of a 0x81 frame
    start(BASE, 8'h81);
    frame(8'h81, -1, 8'h00);
    start(BASE, 8'h55);
    frame(8'h55, -1, 8'h00);
    chk_status("b2b_no_ovr", 1'b0);

    // unaligned low address bits still select TXDATA
    idle_cycle();
    start(BASE + 32'd3, 8'h12);
    frame(8'h12, -1, 8'h00);
    chk_txdata("unaligned_txdata");

    // randomized frames, intrusions, gaps and overrun clears
    for (int r = 0; r < 10; r++) begin
      b   = 8'($urandom);
      sel = int'($urandom_range(0, 3));
      if (sel == 0)      intr = -1;
      else if (sel == 1) intr = int'(10 * N) - 1;
      else               intr = int'($urandom_range(0, 10 * N - 2));
      start(BASE + 32'($urandom_range(0, 3)), b);
      frame(b, intr, 8'($urandom));
      chk_status("rand_status_end", 1'b0);
      if (m_ovr && ($urandom_range(0, 1) == 1)) begin
        write_status(32'h2);
        m_ovr = 1'b0;
        chk("rand_clear_done", 32'(tx_done), 32'd0);
        chk_status("rand_status_cleared", 1'b0);
      end
      repeat ($urandom_range(0, 2)) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
